// File: rtl/onn_pkg.sv
// Shared types and constants for the ONN neuron control block.
// Holds the phase width default, FSM encoding and counter sizing.
package onn_pkg;

  localparam int PHASE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    RUN     = 2'd2,
    SETTLED = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/phase_chan_reg.sv
// One neuron channel: registered phase, last sample, change pulse.
// PHASE_GLITCH_FILTER_EN adds a 2-sample agreement candidate register.
module phase_chan_reg
  import onn_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               ld_i,
  input  logic               trk_i,
  input  logic [PHASE_W-1:0] ini_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic [PHASE_W-1:0] phi_o,
  output logic               chg_o,
  output logic               flag_o
);

  logic [PHASE_W-1:0] phi_q, phi_d;
  logic [PHASE_W-1:0] prev_q, prev_d;
  logic               flag_q, flag_d;
  logic               chg;

`ifdef PHASE_GLITCH_FILTER_EN
  logic [PHASE_W-1:0] cand_q, cand_d;

  // prev_q is the last committed value; cand_q the raw previous sample
  assign chg = trk_i && (phase_i == cand_q) && (cand_q != prev_q);
`else
  assign chg = trk_i && (phase_i != prev_q);
`endif

  always_comb begin
    phi_d  = phi_q;
    prev_d = prev_q;
    flag_d = 1'b0;
`ifdef PHASE_GLITCH_FILTER_EN
    cand_d = cand_q;
`endif
    unique case (1'b1)
      clr_i: begin
        phi_d  = '0;
        prev_d = '0;
`ifdef PHASE_GLITCH_FILTER_EN
        cand_d = '0;
`endif
      end
      ld_i: begin
        phi_d  = ini_i;
        prev_d = phase_i;
`ifdef PHASE_GLITCH_FILTER_EN
        cand_d = phase_i;
`endif
      end
      trk_i: begin
        flag_d = chg;
        if (chg) phi_d = phase_i;
`ifdef PHASE_GLITCH_FILTER_EN
        cand_d = phase_i;
        if (chg) prev_d = phase_i;
`else
        prev_d = phase_i;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_q  <= '0;
      prev_q <= '0;
      flag_q <= 1'b0;
`ifdef PHASE_GLITCH_FILTER_EN
      cand_q <= '0;
`endif
    end else begin
      phi_q  <= phi_d;
      prev_q <= prev_d;
      flag_q <= flag_d;
`ifdef PHASE_GLITCH_FILTER_EN
      cand_q <= cand_d;
`endif
    end
  end

  assign phi_o  = phi_q;
  assign chg_o  = chg;
  assign flag_o = flag_q;

endmodule

// File: rtl/phase_reg_bank.sv
// Multi-channel ONN phase register bank with settling detection.
// Optional macro PHASE_GLITCH_FILTER_EN enables per-channel glitch filter.
module phase_reg_bank
  import onn_pkg::*;
#(
  parameter int N_CH          = 8,
  parameter int PHASE_W       = PHASE_W_DEF,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               full_tick,
  input  logic [N_CH*PHASE_W-1:0]            ini_phase,
  input  logic [N_CH*PHASE_W-1:0]            phase,
  output logic [N_CH*PHASE_W-1:0]            phi_out,
  output logic [N_CH-1:0]                    state_changed,
  output logic                               any_changed,
  output logic                               settled,
  output logic [$clog2(STABLE_CYCLES+1)-1:0] stable_cnt
);

  localparam int CW = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            set_q, set_d;
  logic            any_q, any_d;
  logic [N_CH-1:0] chg_v;
  logic            any_chg;
  logic            ld;
  logic            trk;

  assign ld  = !clr && !full_tick;
  assign trk = !clr && full_tick &&
               ((state_q == RUN) || (state_q == SETTLED));
  assign any_chg = |chg_v;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    phase_chan_reg #(
      .PHASE_W (PHASE_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .ld_i    (ld),
      .trk_i   (trk),
      .ini_i   (ini_phase[k*PHASE_W +: PHASE_W]),
      .phase_i (phase[k*PHASE_W +: PHASE_W]),
      .phi_o   (phi_out[k*PHASE_W +: PHASE_W]),
      .chg_o   (chg_v[k]),
      .flag_o  (state_changed[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    any_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      set_d   = 1'b0;
    end else if (!full_tick) begin
      state_d = INIT;
      cnt_d   = '0;
      set_d   = 1'b0;
    end else begin
      case (state_q)
        INIT:    state_d = RUN;
        RUN, SETTLED: begin
          any_d = any_chg;
          if (any_chg) begin
            state_d = RUN;
            cnt_d   = '0;
            set_d   = 1'b0;
          end else begin
            if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (state_q == RUN && cnt_q == CNT_PRE) begin
              state_d = SETTLED;
              set_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      any_q   <= any_d;
    end
  end

  assign any_changed = any_q;
  assign settled     = set_q;
  assign stable_cnt  = cnt_q;

endmodule

// File: tb/tb_phase_reg_bank.sv
// Directed bench for phase_reg_bank (N_CH=4, PHASE_W=4, STABLE_CYCLES=8).
// Glitch-filter sequence replaces the table when PHASE_GLITCH_FILTER_EN is set.
module tb_phase_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        full_tick;
  logic [15:0] ini_phase;
  logic [15:0] phase;
  logic [15:0] phi_out;
  logic [3:0]  state_changed;
  logic        any_changed;
  logic        settled;
  logic [3:0]  stable_cnt;

  int checks   = 0;
  int failures = 0;

  phase_reg_bank #(
    .N_CH          (4),
    .PHASE_W       (4),
    .STABLE_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .full_tick     (full_tick),
    .ini_phase     (ini_phase),
    .phase         (phase),
    .phi_out       (phi_out),
    .state_changed (state_changed),
    .any_changed   (any_changed),
    .settled       (settled),
    .stable_cnt    (stable_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        ft;
    logic [15:0] ini;
    logic [15:0] ph;
    logic [15:0] phi;
    logic [3:0]  sc;
    logic        any;
    logic        st;
    logic [3:0]  cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic ft,
                      input logic [15:0] ini, input logic [15:0] ph);
    clr       = c;
    full_tick = ft;
    ini_phase = ini;
    phase     = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string p, input logic [15:0] phi,
                         input logic [3:0] sc, input logic any,
                         input logic st, input logic [3:0] cnt);
    chk({p, "_phi"}, 32'(phi_out), 32'(phi));
    chk({p, "_sc"}, 32'(state_changed), 32'(sc));
    chk({p, "_any"}, 32'(any_changed), 32'(any));
    chk({p, "_set"}, 32'(settled), 32'(st));
    chk({p, "_cnt"}, 32'(stable_cnt), 32'(cnt));
  endtask

  vec_t tbl[25];

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    full_tick = 1'b1;
    ini_phase = '0;
    phase     = '0;
    @(posedge clk);
    #1;
    chk_all("reset", 16'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef PHASE_GLITCH_FILTER_EN
    //            clr   ft    ini       ph        phi       sc     any   st    cnt
    tbl[0]  = '{1'b0, 1'b0, 16'h4321, 16'h4321, 16'h4321, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'h4321, 16'h4321, 16'h4321, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h4321, 16'h4321, 16'h4321, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 16'h0000, 16'h4321, 16'h4321, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h2, 1'b1, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd1};
    tbl[6]  = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd2};
    tbl[7]  = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd3};
    tbl[8]  = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd4};
    tbl[9]  = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd5};
    tbl[10] = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd6};
    tbl[11] = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b0, 4'd7};
    tbl[12] = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b1, 4'd8};
    tbl[13] = '{1'b0, 1'b1, 16'h0000, 16'h4381, 16'h4381, 4'h0, 1'b0, 1'b1, 4'd8};
    tbl[14] = '{1'b0, 1'b1, 16'h0000, 16'h5381, 16'h5381, 4'h8, 1'b1, 1'b0, 4'd0};
    tbl[15] = '{1'b0, 1'b1, 16'h0000, 16'h538F, 16'h538F, 4'h1, 1'b1, 1'b0, 4'd0};
    tbl[16] = '{1'b0, 1'b1, 16'h0000, 16'h5380, 16'h5380, 4'h1, 1'b1, 1'b0, 4'd0};
    tbl[17] = '{1'b1, 1'b0, 16'h1234, 16'h5380, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[18] = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[19] = '{1'b0, 1'b1, 16'h0000, 16'h2222, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[20] = '{1'b0, 1'b0, 16'hAAAA, 16'h1111, 16'hAAAA, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[21] = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'hAAAA, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[22] = '{1'b0, 1'b1, 16'h0000, 16'h2222, 16'h2222, 4'hF, 1'b1, 1'b0, 4'd0};
    tbl[23] = '{1'b0, 1'b1, 16'h0000, 16'h2222, 16'h2222, 4'h0, 1'b0, 1'b0, 4'd1};
    tbl[24] = '{1'b0, 1'b1, 16'h0000, 16'h2202, 16'h2202, 4'h2, 1'b1, 1'b0, 4'd0};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].clr, tbl[i].ft, tbl[i].ini, tbl[i].ph);
      chk_all($sformatf("v%0d", i), tbl[i].phi, tbl[i].sc,
              tbl[i].any, tbl[i].st, tbl[i].cnt);
    end
`else
    step(1'b0, 1'b0, 16'h0001, 16'h0001);
    step(1'b0, 1'b0, 16'h0001, 16'h0001);
    step(1'b0, 1'b1, 16'h0000, 16'h0001);
    chk_all("f_run", 16'h0001, 4'h0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 16'h0000, 16'h0007);
    chk_all("f_glitch", 16'h0001, 4'h0, 1'b0, 1'b0, 4'd1);
    step(1'b0, 1'b1, 16'h0000, 16'h0001);
    chk_all("f_back", 16'h0001, 4'h0, 1'b0, 1'b0, 4'd2);
    step(1'b0, 1'b1, 16'h0000, 16'h0007);
    chk_all("f_cand", 16'h0001, 4'h0, 1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b1, 16'h0000, 16'h0007);
    chk_all("f_commit", 16'h0007, 4'h1, 1'b1, 1'b0, 4'd0);
`endif

    // asynchronous reset mid-RUN, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 16'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0000, 16'h3333);
    step(1'b0, 1'b1, 16'h0000, 16'h4444);
    chk_all("idle_hold", 16'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 16'h0F0F, 16'h4444);
    chk_all("reinit", 16'h0F0F, 4'h0, 1'b0, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
